// File: rtl/tpm_fifo_pkg.sv
// Shared types and constants for the TPM FIFO command/response engine.
package tpm_fifo_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCmdHdr,
        StCmdBody,
        StCmdErr,
        StTpmGoWait,
        StCmdOut,
        StExec,
        StRspLoad,
        StRspOut,
        StRspDone
    } tpmState_t;

    // Big-endian command size occupies header bytes 2..5.
    localparam int SIZE_OFS_FIRST  = 2;
    localparam int SIZE_OFS_LAST   = 5;
    localparam int HDR_LEN_DEFAULT = 10;

    localparam logic [7:0] IDLE_READ_BYTE = 8'hFF;

endpackage

// File: rtl/tpm_buf_ram.sv
// Single-port synchronous buffer RAM with registered read (read-before-write).
module tpm_buf_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wren,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/tpm_fifo_engine.sv
// FIFO-interface TPM command/response buffer: collects an FRS command, hands it to
// the CRB, loads the CRB response and streams it back with TPM_STS status.
module tpm_fifo_engine
    import tpm_fifo_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int AW        = $clog2(DEPTH),
    parameter int BURST_MAX = 64,
    parameter int HDR_LEN   = HDR_LEN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_wrValid,
    input  logic [7:0]    f_wrByte,
    input  logic          f_rdReq,
    output logic [7:0]    f_rdByte,
    output logic          f_rdValid,
    input  logic          f_abort,
    input  logic          r_tpmGo,
    input  logic          r_commandReady,
    input  logic          r_responseRetry,
    output logic          s_expect,
    output logic          s_dataAvail,
    output logic [15:0]   s_burstCount,
    output logic          s_overflow,
    output logic [31:0]   c_cmdSize,
    output logic          c_cmdSend,
    input  logic [AW-1:0] c_cmdAddr,
    output logic [7:0]    c_cmdByte,
    input  logic          c_cmdDone,
    input  logic          e_execDone,
    input  logic [31:0]   c_rspSize,
    input  logic          c_rspWrEn,
    input  logic [AW-1:0] c_rspAddr,
    input  logic [7:0]    c_rspByte,
    input  logic          c_rspDone
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] BURST_W = BURST_MAX[AW:0];
    localparam logic [AW:0] OFS_FIRST_W = SIZE_OFS_FIRST[AW:0];
    localparam logic [AW:0] OFS_LAST_W  = SIZE_OFS_LAST[AW:0];
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);
    localparam logic [31:0] HDR32   = 32'(HDR_LEN);

    tpmState_t   state, stateNext;
    logic [AW:0] wptr, wptrNext, rptr, rptrNext;
    logic [31:0] size, sizeNext, hdrSize;
    logic        overflow, overflowNext;
    logic        softClr, crHonoured;
    logic        cmdSendNext, rdVldNext, rdIdleNext;
    logic        cmdSend_p1, rdVld_p1, rdIdle_p1, cmdRd_p1;
    logic        ramWren;
    logic [AW-1:0] ramAddr;
    logic [7:0]  ramWdata, ramRdata;
    logic [AW:0] burstRaw;

    function automatic logic [AW:0] satBurst(input logic [AW:0] avail);
        return (avail > BURST_W) ? BURST_W : avail;
    endfunction

    // Out-of-range response sizes fall back to a full buffer rather than erroring.
    function automatic logic [31:0] clampRspSize(input logic [31:0] req);
        return (req < HDR32 || req > DEPTH32) ? DEPTH32 : req;
    endfunction

    always_comb begin
        crHonoured = r_commandReady &&
                     !(state inside {StCmdOut, StExec, StRspLoad});
        softClr = f_abort || crHonoured;
    end

    always_comb begin
        stateNext    = state;
        wptrNext     = wptr;
        rptrNext     = rptr;
        sizeNext     = size;
        overflowNext = overflow;
        cmdSendNext  = 1'b0;
        rdVldNext    = 1'b0;
        rdIdleNext   = 1'b0;
        ramWren      = 1'b0;
        ramAddr      = wptr[AW-1:0];
        ramWdata     = f_wrByte;
        hdrSize      = {size[23:0], f_wrByte};
        if (softClr) begin
            stateNext    = StIdle;
            wptrNext     = '0;
            rptrNext     = '0;
            sizeNext     = '0;
            overflowNext = 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    ramAddr = '0;
                    if (f_wrValid) begin
                        ramWren   = 1'b1;
                        wptrNext  = {{AW{1'b0}}, 1'b1};
                        stateNext = StCmdHdr;
                    end
                end
                StCmdHdr: begin
                    if (f_wrValid) begin
                        ramWren  = 1'b1;
                        wptrNext = wptr + 1'b1;
                        if (wptr >= OFS_FIRST_W && wptr <= OFS_LAST_W) begin
                            sizeNext = hdrSize;
                        end
                        if (wptr == OFS_LAST_W) begin
                            if (hdrSize < HDR32 || hdrSize > DEPTH32) begin
                                stateNext    = StCmdErr;
                                overflowNext = 1'b1;
                            end else if (hdrSize == 32'(wptr) + 32'd1) begin
                                stateNext = StTpmGoWait;
                            end else begin
                                stateNext = StCmdBody;
                            end
                        end
                    end
                end
                StCmdBody: begin
                    if (f_wrValid) begin
                        ramWren  = 1'b1;
                        wptrNext = wptr + 1'b1;
                        if (32'(wptr) + 32'd1 == size) begin
                            stateNext = StTpmGoWait;
                        end
                    end
                end
                StCmdErr: begin
                end
                StTpmGoWait: begin
                    if (f_wrValid) begin
                        overflowNext = 1'b1;
                    end
                    if (r_tpmGo) begin
                        stateNext   = StCmdOut;
                        cmdSendNext = 1'b1;
                    end
                end
                StCmdOut: begin
                    ramAddr = c_cmdAddr;
                    if (c_cmdDone) begin
                        stateNext = StExec;
                    end
                end
                StExec: begin
                    if (e_execDone) begin
                        sizeNext  = clampRspSize(c_rspSize);
                        stateNext = StRspLoad;
                    end
                end
                StRspLoad: begin
                    ramAddr  = c_rspAddr;
                    ramWdata = c_rspByte;
                    ramWren  = c_rspWrEn;
                    if (c_rspDone) begin
                        rptrNext  = '0;
                        stateNext = StRspOut;
                    end
                end
                StRspOut, StRspDone: begin
                    ramAddr = rptr[AW-1:0];
                    if (r_responseRetry) begin
                        rptrNext  = '0;
                        stateNext = StRspOut;
                    end else if (f_rdReq) begin
                        rdVldNext = 1'b1;
                        if (32'(rptr) < size) begin
                            rptrNext = rptr + 1'b1;
                            if (32'(rptr) + 32'd1 == size) begin
                                stateNext = StRspDone;
                            end
                        end else begin
                            rdIdleNext = 1'b1;
                        end
                    end
                end
                default: stateNext = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Stage p1: registered strobes aligned with the RAM read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            size       <= '0;
            overflow   <= 1'b0;
            cmdSend_p1 <= 1'b0;
            rdVld_p1   <= 1'b0;
            rdIdle_p1  <= 1'b0;
            cmdRd_p1   <= 1'b0;
        end else begin
            wptr       <= wptrNext;
            rptr       <= rptrNext;
            size       <= sizeNext;
            overflow   <= overflowNext;
            cmdSend_p1 <= cmdSendNext;
            rdVld_p1   <= rdVldNext;
            rdIdle_p1  <= rdIdleNext;
            cmdRd_p1   <= !softClr && (state == StCmdOut);
        end
    end

    tpm_buf_ram #(
        .WIDTH(8),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) uBufRam (
        .clock(clock),
        .wren (ramWren),
        .addr (ramAddr),
        .wdata(ramWdata),
        .rdata(ramRdata)
    );

    always_comb begin
        unique case (state)
            StCmdHdr:  burstRaw = satBurst(DEPTH_W - wptr);
            StCmdBody: burstRaw = satBurst(size[AW:0] - wptr);
            StRspOut:  burstRaw = satBurst(size[AW:0] - rptr);
            default:   burstRaw = '0;
        endcase
    end

    assign s_burstCount = 16'(burstRaw);
    assign s_expect     = (state == StCmdHdr) || (state == StCmdBody);
    assign s_dataAvail  = (state == StRspOut) && (32'(rptr) < size);
    assign s_overflow   = overflow;
    assign c_cmdSize    = size;
    assign c_cmdSend    = cmdSend_p1;
    assign c_cmdByte    = cmdRd_p1 ? ramRdata : 8'h00;
    assign f_rdValid    = rdVld_p1;
    assign f_rdByte     = !rdVld_p1 ? 8'h00 : (rdIdle_p1 ? IDLE_READ_BYTE : ramRdata);

endmodule

// File: tb/tb_tpm_fifo_engine.sv
// Scoreboard bench for tpm_fifo_engine: directed command/response sequences.
module tb_tpm_fifo_engine;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          f_wrValid = 1'b0;
    logic [7:0]    f_wrByte = 8'h00;
    logic          f_rdReq = 1'b0;
    logic [7:0]    f_rdByte;
    logic          f_rdValid;
    logic          f_abort = 1'b0;
    logic          r_tpmGo = 1'b0;
    logic          r_commandReady = 1'b0;
    logic          r_responseRetry = 1'b0;
    logic          s_expect;
    logic          s_dataAvail;
    logic [15:0]   s_burstCount;
    logic          s_overflow;
    logic [31:0]   c_cmdSize;
    logic          c_cmdSend;
    logic [AW-1:0] c_cmdAddr = '0;
    logic [7:0]    c_cmdByte;
    logic          c_cmdDone = 1'b0;
    logic          e_execDone = 1'b0;
    logic [31:0]   c_rspSize = '0;
    logic          c_rspWrEn = 1'b0;
    logic [AW-1:0] c_rspAddr = '0;
    logic [7:0]    c_rspByte = 8'h00;
    logic          c_rspDone = 1'b0;

    int total = 0;
    int bad = 0;
    int sendCount = 0;
    logic [7:0] rspQ [$];
    logic [7:0] cmdQ [$];
    logic cmdRdIss = 1'b0;
    logic cmdRdVld = 1'b0;

    logic [7:0] cmdBytes [12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
                                  8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    logic [7:0] rspBytes [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A,
                                  8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] errHdr [6]    = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01};
    logic [7:0] shortCmd [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A,
                                  8'h00, 8'h00, 8'h01, 8'h7B};
    logic [7:0] smallHdr [6]  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09};

    tpm_fifo_engine #(
        .DEPTH    (4096),
        .AW       (AW),
        .BURST_MAX(64),
        .HDR_LEN  (10)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .f_wrValid      (f_wrValid),
        .f_wrByte       (f_wrByte),
        .f_rdReq        (f_rdReq),
        .f_rdByte       (f_rdByte),
        .f_rdValid      (f_rdValid),
        .f_abort        (f_abort),
        .r_tpmGo        (r_tpmGo),
        .r_commandReady (r_commandReady),
        .r_responseRetry(r_responseRetry),
        .s_expect       (s_expect),
        .s_dataAvail    (s_dataAvail),
        .s_burstCount   (s_burstCount),
        .s_overflow     (s_overflow),
        .c_cmdSize      (c_cmdSize),
        .c_cmdSend      (c_cmdSend),
        .c_cmdAddr      (c_cmdAddr),
        .c_cmdByte      (c_cmdByte),
        .c_cmdDone      (c_cmdDone),
        .e_execDone     (e_execDone),
        .c_rspSize      (c_rspSize),
        .c_rspWrEn      (c_rspWrEn),
        .c_rspAddr      (c_rspAddr),
        .c_rspByte      (c_rspByte),
        .c_rspDone      (c_rspDone)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cmdRdVld <= cmdRdIss;

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clock) begin
        logic [7:0] expByte;
        if (c_cmdSend) sendCount++;
        if (f_rdValid) begin
            total++;
            if (rspQ.size() == 0) begin
                bad++;
                $display("FAIL rdValid_unexpected: got byte %0h with nothing expected", f_rdByte);
            end else begin
                expByte = rspQ.pop_front();
                if (f_rdByte !== expByte) begin
                    bad++;
                    $display("FAIL rdByte: got %0h expected %0h", f_rdByte, expByte);
                end
            end
        end
        if (cmdRdVld) begin
            total++;
            if (cmdQ.size() == 0) begin
                bad++;
                $display("FAIL cmdByte_unexpected: got %0h with nothing expected", c_cmdByte);
            end else begin
                expByte = cmdQ.pop_front();
                if (c_cmdByte !== expByte) begin
                    bad++;
                    $display("FAIL cmdByte: got %0h expected %0h", c_cmdByte, expByte);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wrByte(input logic [7:0] b);
        f_wrValid = 1'b1;
        f_wrByte  = b;
        step();
        f_wrValid = 1'b0;
    endtask

    task automatic rdReq(input logic [7:0] expByte);
        rspQ.push_back(expByte);
        f_rdReq = 1'b1;
        step();
        f_rdReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state.
        step();
        step();
        check("rst_expect", 32'(s_expect), 0);
        check("rst_burst", 32'(s_burstCount), 0);
        check("rst_overflow", 32'(s_overflow), 0);
        check("rst_rdValid", 32'(f_rdValid), 0);
        check("rst_cmdSize", c_cmdSize, 0);
        reset = 1'b0;
        step();

        // Well-formed 12-byte command.
        wrByte(cmdBytes[0]);
        check("hdr_expect", 32'(s_expect), 1);
        check("hdr_burst", 32'(s_burstCount), 64);
        for (int i = 1; i < 6; i++) wrByte(cmdBytes[i]);
        check("cmdSize", c_cmdSize, 12);
        check("body_burst", 32'(s_burstCount), 6);
        for (int i = 6; i < 11; i++) wrByte(cmdBytes[i]);
        check("body_last_expect", 32'(s_expect), 1);
        check("body_last_burst", 32'(s_burstCount), 1);
        wrByte(cmdBytes[11]);
        check("done_expect", 32'(s_expect), 0);
        check("done_burst", 32'(s_burstCount), 0);
        check("done_overflow", 32'(s_overflow), 0);

        // Extra byte after a complete command.
        wrByte(8'hAA);
        check("extra_overflow", 32'(s_overflow), 1);
        check("extra_expect", 32'(s_expect), 0);

        r_tpmGo = 1'b1;
        step();
        r_tpmGo = 1'b0;
        check("cmdSend_pulse", 32'(c_cmdSend), 1);
        for (int i = 0; i < 12; i++) begin
            c_cmdAddr = AW'(i);
            cmdRdIss = 1'b1;
            cmdQ.push_back(cmdBytes[i]);
            step();
            if (i == 0) check("cmdSend_single", 32'(c_cmdSend), 0);
        end
        cmdRdIss = 1'b0;
        c_cmdDone = 1'b1;
        step();
        c_cmdDone = 1'b0;
        check("sendCount_go", 32'(sendCount), 1);

        // commandReady is ignored while executing.
        r_commandReady = 1'b1;
        step();
        r_commandReady = 1'b0;
        check("exec_cr_cmdSize", c_cmdSize, 12);
        check("exec_cr_overflow", 32'(s_overflow), 1);

        e_execDone = 1'b1;
        c_rspSize  = 32'd10;
        step();
        e_execDone = 1'b0;
        check("rspSize", c_cmdSize, 10);
        for (int i = 0; i < 10; i++) begin
            c_rspWrEn = 1'b1;
            c_rspAddr = AW'(i);
            c_rspByte = rspBytes[i];
            step();
        end
        c_rspWrEn = 1'b0;
        c_rspDone = 1'b1;
        step();
        c_rspDone = 1'b0;
        check("rsp_dataAvail", 32'(s_dataAvail), 1);
        check("rsp_burst", 32'(s_burstCount), 10);

        for (int i = 0; i < 10; i++) begin
            rdReq(rspBytes[i]);
            if (i == 0) check("rd_latency", 32'(f_rdValid), 1);
        end
        check("rd_end_dataAvail", 32'(s_dataAvail), 0);
        rdReq(8'hFF);
        r_responseRetry = 1'b1;
        step();
        r_responseRetry = 1'b0;
        check("retry_dataAvail", 32'(s_dataAvail), 1);
        check("retry_burst", 32'(s_burstCount), 10);
        rdReq(rspBytes[0]);
        check("retry_burst_after", 32'(s_burstCount), 9);

        // Asynchronous reset in the middle of RspOut.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_rdValid", 32'(f_rdValid), 0);
        check("arst_rdByte", 32'(f_rdByte), 0);
        check("arst_dataAvail", 32'(s_dataAvail), 0);
        check("arst_overflow", 32'(s_overflow), 0);
        check("arst_burst", 32'(s_burstCount), 0);
        check("arst_cmdSize", c_cmdSize, 0);
        step();
        reset = 1'b0;
        step();

        // Oversized header: 0x1001 > DEPTH.
        for (int i = 0; i < 6; i++) wrByte(errHdr[i]);
        check("err_overflow", 32'(s_overflow), 1);
        check("err_expect", 32'(s_expect), 0);
        check("err_burst", 32'(s_burstCount), 0);
        for (int i = 0; i < 3; i++) wrByte(8'h55);
        check("err_drop_expect", 32'(s_expect), 0);
        r_tpmGo = 1'b1;
        step();
        r_tpmGo = 1'b0;
        check("err_tpmGo_send", 32'(c_cmdSend), 0);
        step();
        check("err_sendCount", 32'(sendCount), 1);
        r_commandReady = 1'b1;
        step();
        r_commandReady = 1'b0;
        check("cr_overflow", 32'(s_overflow), 0);
        check("cr_cmdSize", c_cmdSize, 0);
        check("cr_expect", 32'(s_expect), 0);

        // Abort in the same cycle as tpmGo.
        for (int i = 0; i < 6; i++) wrByte(shortCmd[i]);
        check("short_burst", 32'(s_burstCount), 4);
        for (int i = 6; i < 10; i++) wrByte(shortCmd[i]);
        check("short_expect", 32'(s_expect), 0);
        f_abort = 1'b1;
        r_tpmGo = 1'b1;
        step();
        f_abort = 1'b0;
        r_tpmGo = 1'b0;
        check("abort_send", 32'(c_cmdSend), 0);
        check("abort_cmdSize", c_cmdSize, 0);
        step();
        check("abort_sendCount", 32'(sendCount), 1);
        wrByte(smallHdr[0]);
        check("abort_idle_expect", 32'(s_expect), 1);
        check("abort_idle_burst", 32'(s_burstCount), 64);

        // Undersized header: 9 < HDR_LEN, then abort clears the error.
        for (int i = 1; i < 6; i++) wrByte(smallHdr[i]);
        check("small_overflow", 32'(s_overflow), 1);
        f_abort = 1'b1;
        step();
        f_abort = 1'b0;
        check("abort_overflow", 32'(s_overflow), 0);
        check("abort_expect", 32'(s_expect), 0);

        step();
        step();
        check("rspQ_drained", 32'(rspQ.size()), 0);
        check("cmdQ_drained", 32'(cmdQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
